// File: rtl/unlock_pkg.sv
// Shared types, width helpers and character constants
// for the parametrised unlock sequence detector.
package unlock_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam logic [7:0] CH_A = 8'h41;
   localparam logic [7:0] CH_B = 8'h42;
   localparam logic [7:0] CH_C = 8'h43;
   localparam logic [7:0] CH_D = 8'h44;

endpackage

// File: rtl/unlock_timer.sv
// Down-counter shared by the OPEN and LOCKOUT windows.
// done is high whenever the count reads zero.
module unlock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // load takes priority; otherwise count down to zero and hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/unlock_seq_param.sv
// Parametrised code lock: fixed-length attempts, timed open
// window with code rewrite, and timed lockout after failures.
module unlock_seq_param
   import unlock_pkg::*;
#(
   parameter int CHAR_W         = 8,
   parameter int CODE_LEN       = 4,
   parameter logic [CODE_LEN*CHAR_W-1:0] DEFAULT_CODE =
      {CH_A, CH_B, CH_C, CH_A},
   parameter int OPEN_CYCLES    = 16,
   parameter int MAX_FAIL       = 3,
   parameter int LOCKOUT_CYCLES = 64
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [CHAR_W-1:0]                    ascii_in,
   input  logic                                 ascii_valid,
   input  logic                                 code_we,
   input  logic [clog2_min1(CODE_LEN)-1:0]      code_idx,
   input  logic [CHAR_W-1:0]                    code_char,
   output logic                                 out,
   output logic                                 fail_pulse,
   output logic                                 locked_out,
   output logic [clog2_min1(MAX_FAIL+1)-1:0]    fail_count
);

   localparam int IW   = clog2_min1(CODE_LEN);
   localparam int FW   = clog2_min1(MAX_FAIL + 1);
   localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                         OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = clog2_min1(TMAX);

   localparam logic [IW-1:0] LAST  = IW'(CODE_LEN - 1);
   localparam logic [IW:0]   LEN_X = CODE_LEN[IW:0];
   localparam logic [FW-1:0] FMAX  = FW'(MAX_FAIL);
   localparam logic [FW-1:0] FLAST = FW'(MAX_FAIL - 1);
   localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);

   state_t            state, state_n;
   logic [IW-1:0]     pos, pos_n;
   logic              mismatch, mis_n;
   logic [FW-1:0]     fail_n;
   logic              pulse_n;
   logic              t_load;
   logic [TW-1:0]     t_val;
   logic              t_done;
   logic [CHAR_W-1:0] code [CODE_LEN];
   logic              miss_now;
   logic              wr_en;

   unlock_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_val),
      .done     (t_done)
   );

   assign miss_now = mismatch | (ascii_in != code[pos]);
   assign wr_en    = code_we && (state == OPEN) &&
                     ({1'b0, code_idx} < LEN_X);

   // code register: reset to the default, writable only while open
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CODE_LEN; i++) begin
            code[i] <= DEFAULT_CODE[(CODE_LEN-1-i)*CHAR_W +: CHAR_W];
         end
      end else if (wr_en) begin
         code[code_idx] <= code_char;
      end
   end

   // state, attempt progress and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= COLLECT;
         pos        <= '0;
         mismatch   <= 1'b0;
         out        <= 1'b0;
         fail_pulse <= 1'b0;
         locked_out <= 1'b0;
         fail_count <= '0;
      end else begin
         state      <= state_n;
         pos        <= pos_n;
         mismatch   <= mis_n;
         out        <= (state_n == OPEN);
         fail_pulse <= pulse_n;
         locked_out <= (state_n == LOCKOUT);
         fail_count <= fail_n;
      end
   end

   // next-state: attempt evaluation and window timing
   always_comb begin
      state_n = state;
      pos_n   = pos;
      mis_n   = mismatch;
      fail_n  = fail_count;
      pulse_n = 1'b0;
      t_load  = 1'b0;
      t_val   = '0;
      case (state)
         COLLECT: begin
            if (ascii_valid) begin
               if (pos == LAST) begin
                  pos_n = '0;
                  mis_n = 1'b0;
                  if (!miss_now) begin
                     state_n = OPEN;
                     t_load  = 1'b1;
                     t_val   = T_OPEN;
                     fail_n  = '0;
                  end else begin
                     pulse_n = 1'b1;
                     if (fail_count == FLAST) begin
                        state_n = LOCKOUT;
                        t_load  = 1'b1;
                        t_val   = T_LOCK;
                        fail_n  = FMAX;
                     end else begin
                        fail_n = fail_count + FW'(1);
                     end
                  end
               end else begin
                  pos_n = pos + IW'(1);
                  mis_n = miss_now;
               end
            end
         end
         OPEN: begin
            if (t_done) begin
               state_n = COLLECT;
            end
         end
         LOCKOUT: begin
            if (t_done) begin
               state_n = COLLECT;
               fail_n  = '0;
            end
         end
         default: begin
            state_n = COLLECT;
         end
      endcase
   end

endmodule

// File: tb/tb_unlock_seq_param.sv
// Randomised and directed bench for unlock_seq_param against
// an attempt-level reference model, plus a small-instance check.
module tb_unlock_seq_param;

   logic       clk;
   logic       reset;
   logic [7:0] ascii_in;
   logic       ascii_valid;
   logic       code_we;
   logic [1:0] code_idx;
   logic [7:0] code_char;
   logic       out;
   logic       fail_pulse;
   logic       locked_out;
   logic [1:0] fail_count;

   logic [3:0] s_in;
   logic       s_valid;
   logic       s_we;
   logic       s_idx;
   logic [3:0] s_char;
   logic       s_out;
   logic       s_pulse;
   logic       s_locked;
   logic       s_fc;

   int checks = 0;
   int failures = 0;

   localparam logic [7:0] A = 8'h41;
   localparam logic [7:0] B = 8'h42;
   localparam logic [7:0] C = 8'h43;
   localparam logic [7:0] D = 8'h44;

   unlock_seq_param dut (
      .clk         (clk),
      .reset       (reset),
      .ascii_in    (ascii_in),
      .ascii_valid (ascii_valid),
      .code_we     (code_we),
      .code_idx    (code_idx),
      .code_char   (code_char),
      .out         (out),
      .fail_pulse  (fail_pulse),
      .locked_out  (locked_out),
      .fail_count  (fail_count)
   );

   unlock_seq_param #(
      .CHAR_W       (4),
      .CODE_LEN     (2),
      .DEFAULT_CODE (8'h3C),
      .OPEN_CYCLES  (1),
      .MAX_FAIL     (1)
   ) sdut (
      .clk         (clk),
      .reset       (reset),
      .ascii_in    (s_in),
      .ascii_valid (s_valid),
      .code_we     (s_we),
      .code_idx    (s_idx),
      .code_char   (s_char),
      .out         (s_out),
      .fail_pulse  (s_pulse),
      .locked_out  (s_locked),
      .fail_count  (s_fc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model: attempt buffer, code and window counters
   logic [7:0] mcode [4];
   logic [7:0] q [$];
   int open_left;
   int lock_left;
   int fails;
   bit mpulse;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mcode = '{A, B, C, A};
      q.delete();
      open_left = 0;
      lock_left = 0;
      fails = 0;
      mpulse = 0;
   endtask

   task automatic model_step();
      mpulse = 0;
      if (open_left > 0) begin
         if (code_we) mcode[code_idx] = code_char;
         open_left--;
      end else if (lock_left > 0) begin
         lock_left--;
         if (lock_left == 0) fails = 0;
      end else if (ascii_valid) begin
         q.push_back(ascii_in);
         if (q.size() == 4) begin
            bit ok = 1;
            for (int i = 0; i < 4; i++) ok &= (q[i] == mcode[i]);
            q.delete();
            if (ok) begin
               open_left = 16;
               fails = 0;
            end else begin
               mpulse = 1;
               fails++;
               if (fails == 3) lock_left = 64;
            end
         end
      end
   endtask

   task automatic check_main();
      check("out", 32'(out), 32'(open_left > 0));
      check("fail_pulse", 32'(fail_pulse), 32'(mpulse));
      check("locked_out", 32'(locked_out), 32'(lock_left > 0));
      check("fail_count", 32'(fail_count), 32'(fails));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_main();
   endtask

   task automatic send(logic [7:0] ch);
      ascii_valid = 1'b1;
      ascii_in = ch;
      tick();
      ascii_valid = 1'b0;
   endtask

   task automatic idle(int n);
      ascii_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send4(logic [7:0] c0, logic [7:0] c1,
                        logic [7:0] c2, logic [7:0] c3);
      send(c0);
      send(c1);
      send(c2);
      send(c3);
   endtask

   task automatic write_code(logic [1:0] idx, logic [7:0] ch);
      code_we = 1'b1;
      code_idx = idx;
      code_char = ch;
      tick();
      code_we = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #3;
      check_main();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      ascii_in = '0;
      ascii_valid = 1'b0;
      code_we = 1'b0;
      code_idx = '0;
      code_char = '0;
      s_in = '0;
      s_valid = 1'b0;
      s_we = 1'b0;
      s_idx = 1'b0;
      s_char = '0;
      model_reset();
      #12;
      check_main();
      check("s_reset_out", 32'(s_out), 32'd0);
      reset = 1'b1;

      // plain unlock and the full open window
      send4(A, B, C, A);
      idle(20);
      // single failure then recovery
      send4(D, C, B, A);
      send4(A, B, C, A);
      idle(18);
      // lockout, ignored input inside it, unlock afterwards
      send4(D, D, D, D);
      send4(A, B, B, A);
      send4(C, C, C, C);
      send4(A, B, C, A);
      idle(62);
      send4(A, B, C, A);
      idle(18);
      // gaps inside an attempt
      send(A);
      idle(5);
      send(B);
      send(C);
      send(A);
      idle(18);
      // reset mid-attempt discards progress
      send(A);
      send(B);
      do_reset();
      send(C);
      send(A);
      idle(3);
      do_reset();
      // code rewrite in OPEN, ignored in COLLECT, reverted by reset
      send4(A, B, C, A);
      write_code(2'd0, D);
      idle(16);
      send4(A, B, C, A);
      send4(D, B, C, A);
      idle(18);
      write_code(2'd0, A);
      send4(D, B, C, A);
      idle(18);
      do_reset();
      send4(A, B, C, A);
      idle(18);

      // randomised traffic
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] pick;
         pick = 8'(A + 8'($urandom_range(0, 3)));
         ascii_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8) ascii_in = mcode[q.size()];
         else ascii_in = pick;
         code_we = ($urandom_range(0, 5) == 0);
         code_idx = 2'($urandom_range(0, 3));
         code_char = 8'(A + 8'($urandom_range(0, 3)));
         if ($urandom_range(0, 499) == 0) do_reset();
         tick();
      end
      ascii_valid = 1'b0;
      code_we = 1'b0;

      // small instance: 1-cycle open, immediate lockout
      do_reset();
      s_valid = 1'b1;
      s_in = 4'h3;
      tick();
      s_in = 4'hC;
      tick();
      check("s_open_out", 32'(s_out), 32'd1);
      check("s_open_pulse", 32'(s_pulse), 32'd0);
      check("s_open_fc", 32'(s_fc), 32'd0);
      s_valid = 1'b0;
      tick();
      check("s_close_out", 32'(s_out), 32'd0);
      s_valid = 1'b1;
      s_in = 4'h3;
      tick();
      s_in = 4'hD;
      tick();
      check("s_fail_pulse", 32'(s_pulse), 32'd1);
      check("s_fail_locked", 32'(s_locked), 32'd1);
      check("s_fail_fc", 32'(s_fc), 32'd1);
      check("s_fail_out", 32'(s_out), 32'd0);
      s_valid = 1'b0;
      tick();
      check("s_pulse_clr", 32'(s_pulse), 32'd0);
      check("s_lock_hold", 32'(s_locked), 32'd1);
      for (int i = 0; i < 62; i++) tick();
      check("s_lock_last", 32'(s_locked), 32'd1);
      tick();
      check("s_lock_exit", 32'(s_locked), 32'd0);
      check("s_exit_fc", 32'(s_fc), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unlock_seq_param.md
Name: unlock_seq_param

Overview:
- Parametrised successor to the fixed ASCII unlock FSM.
- Collects fixed-length attempts of CODE_LEN characters, qualified by a valid strobe, and compares each attempt against a code register.
- On a match, holds the lock open for a timed window. The code can be rewritten only while open.
- After MAX_FAIL consecutive bad attempts, enters a timed lockout and ignores input.

Parameters:
- CHAR_W, 8, width of one input character
- CODE_LEN, 4, characters per attempt (>=1)
- DEFAULT_CODE, "ABCA", CODE_LEN*CHAR_W reset code; first character in the most-significant slot
- OPEN_CYCLES, 16, cycles out stays high after a match (>=1)
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
- LOCKOUT_CYCLES, 64, lockout duration in cycles (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- ascii_in  in  CHAR_W  input character
- ascii_valid  in  1  ascii_in sampled only when high
- code_we  in  1  code write strobe
- code_idx  in  $clog2(CODE_LEN) (min 1)  character slot to write; 0 = first character
- code_char  in  CHAR_W  new character for slot code_idx
- out  out  1  unlocked level
- fail_pulse  out  1  one-cycle pulse per failed attempt
- locked_out  out  1  high during lockout
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures so far

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT, pos=0, mismatch=0, timer=0.
  - out, fail_pulse, locked_out and fail_count = 0.
  - code = DEFAULT_CODE.
  - Reset mid-attempt, mid-open or mid-lockout discards all progress and reverts any written code.
- All outputs are registered.
- COLLECT:
  - Each clock with ascii_valid=1 compares ascii_in to code[pos]. Set mismatch if they differ, then increment pos.
  - Cycles with ascii_valid=0 hold all state; gaps of any length are allowed.
- Attempt completion (valid character at pos=CODE_LEN-1), decided on that same edge:
  - pos and mismatch clear.
  - Match (no mismatch, including the last character): go to OPEN. out=1 from the edge that sampled the last character. fail_count clears to 0.
  - Mismatch: fail_pulse=1 for exactly one cycle and fail_count increments.
  - If the incremented count equals MAX_FAIL: go to LOCKOUT, locked_out=1 from the same edge, fail_count reads MAX_FAIL.
- No sliding match:
  - An attempt is always exactly CODE_LEN valid characters.
  - Overlapping sequences are not detected, e.g. "XABCA" with code "ABCA" is one fail plus a partial attempt.
- OPEN:
  - out=1 for exactly OPEN_CYCLES cycles, then COLLECT with out=0.
  - ascii_valid is ignored; characters in OPEN are not part of any attempt.
- Code writes:
  - code_we=1 with code_idx<CODE_LEN writes code[code_idx]=code_char on that edge.
  - Writes are accepted only in OPEN, including its final cycle. In all other states, and for code_idx>=CODE_LEN, they are ignored.
  - A new code applies from the next attempt.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles. ascii_valid and code_we are ignored.
  - On exit: COLLECT, locked_out=0, fail_count=0.
- Timer:
  - One down-counter shared by OPEN and LOCKOUT.
  - Loaded with (duration-1) on entry. The state exits on the edge where it reads 0.
- Simultaneous events: code_we together with the OPEN-expiry edge still writes. ascii_valid on the OPEN/LOCKOUT exit edge is ignored; the first sampled character is on the following cycle.
- Outputs are one-hot-exclusive: out and locked_out are never both high.

Decomposition:
- Package unlock_pkg:
  - state encoding (COLLECT, OPEN, LOCKOUT)
  - width helper functions: clog2 with minimum 1
  - default character constants
- Sub-module unlock_timer:
  - ports: clk, reset, load, load_val, done
  - instantiated once, shared by OPEN and LOCKOUT.
- Code storage, comparator and FSM stay in the top module.

Test Plan:
1. Release reset; valid A,B,C,A on consecutive cycles -> out rises after the 4th-character edge, high exactly 16 cycles, then 0; fail_count=0 throughout.
2. D,C,B,A -> fail_pulse one cycle after the 4th character, fail_count=1, out=0. Then A,B,C,A -> out=1, fail_count=0.
3. Three wrong attempts -> locked_out=1 for exactly 64 cycles, fail_count=3. A,B,C,A during lockout -> no effect. After exit fail_count=0; A,B,C,A unlocks.
4. A, five idle cycles (ascii_valid=0), then B,C,A -> unlock. Separately: A,B, pulse reset low for 3 ns, then C,A -> no unlock, no fail_pulse (pos=2 only).
5. Code rewrite:
   - In OPEN write idx0='D' -> after OPEN, A,B,C,A fails and D,B,C,A unlocks.
   - A write attempted in COLLECT is ignored.
   - Reset restores "ABCA".
6. Instance CHAR_W=4, CODE_LEN=2, DEFAULT_CODE=8'h3C, OPEN_CYCLES=1, MAX_FAIL=1 -> 3,C opens out for 1 cycle; 3,D gives fail_pulse and locked_out together on the same edge.
